// File: rtl/eq_scheduler_if.sv
// Request/result bundle for the time-shared equation scheduler.
interface eq_scheduler_if;
  logic        start;
  logic [1:0]  eq_sel;
  logic [7:0]  x1;
  logic [7:0]  x2;
  logic [7:0]  v;
  logic [7:0]  t;
  logic [7:0]  c;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [7:0]  eq_count;

  modport master (
    output start, eq_sel, x1, x2, v, t, c,
    input  A, B, busy, done, eq_count
  );

  modport slave (
    input  start, eq_sel, x1, x2, v, t, c,
    output A, B, busy, done, eq_count
  );
endinterface

// File: rtl/eq_scheduler.sv
// Evaluates A = x1 + v*t and B = x2 + c*t through one shared multiplier and adder.
//   state   | meaning
//   IDLE    | waiting for start with a nonzero eq_sel
//   MUL_A   | prod <= v*t
//   ADD_A   | A <= x1 + prod
//   MUL_B   | prod <= c*t
//   ADD_B   | B <= x2 + prod
//   DONE    | done pulse, count the request
module eq_scheduler (
  input  logic          clk,
  input  logic          rst_n,
  eq_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_MUL_A, S_ADD_A, S_MUL_B, S_ADD_B, S_DONE
  } state_t;

  state_t      r_state;
  logic [7:0]  r_x1, r_x2, r_v, r_t, r_c;
  logic [1:0]  r_sel;
  logic [15:0] r_prod;
  logic [15:0] r_a, r_b;
  logic        r_busy, r_done;
  logic [7:0]  r_cnt;

  logic [7:0]  w_mul_in;
  logic [15:0] w_prod;
  logic [7:0]  w_add_in;
  logic [15:0] w_sum;

  // Operand muxes in front of the single multiplier and single adder.
  assign w_mul_in = (r_state == S_MUL_A) ? r_v : r_c;
  assign w_prod   = {8'h00, w_mul_in} * {8'h00, r_t};
  assign w_add_in = (r_state == S_ADD_A) ? r_x1 : r_x2;
  assign w_sum    = {8'h00, w_add_in} + r_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_x1    <= 8'h00;
      r_x2    <= 8'h00;
      r_v     <= 8'h00;
      r_t     <= 8'h00;
      r_c     <= 8'h00;
      r_sel   <= 2'b00;
      r_prod  <= 16'h0000;
      r_a     <= 16'h0000;
      r_b     <= 16'h0000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start && (bus.eq_sel != 2'b00)) begin
            r_x1    <= bus.x1;
            r_x2    <= bus.x2;
            r_v     <= bus.v;
            r_t     <= bus.t;
            r_c     <= bus.c;
            r_sel   <= bus.eq_sel;
            r_busy  <= 1'b1;
            r_state <= bus.eq_sel[0] ? S_MUL_A : S_MUL_B;
          end
        end
        S_MUL_A: begin
          r_prod  <= w_prod;
          r_state <= S_ADD_A;
        end
        S_ADD_A: begin
          r_a <= w_sum;
          if (r_sel[1]) begin
            r_state <= S_MUL_B;
          end else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_MUL_B: begin
          r_prod  <= w_prod;
          r_state <= S_ADD_B;
        end
        S_ADD_B: begin
          r_b     <= w_sum;
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_cnt   <= r_cnt + 8'd1;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.A        = r_a;
  assign bus.B        = r_b;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.eq_count = r_cnt;

endmodule

// File: tb/tb_eq_scheduler.sv
// Scoreboard bench for eq_scheduler: expected results queued at stimulus, checked at done.
module tb_eq_scheduler;

  logic clk;
  logic rst_n;
  eq_scheduler_if bus ();

  eq_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  cnt;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks;
  int          n_fail;
  logic [15:0] m_a;
  logic [15:0] m_b;
  logic [7:0]  m_cnt;

  // Reference model: pushes the expected outcome of one accepted request.
  task automatic push_expected(input logic [1:0] sel, input logic [7:0] x1, x2, v, t, c);
    exp_t e;
    if (sel[0]) m_a = 16'(x1) + 16'(v) * 16'(t);
    if (sel[1]) m_b = 16'(x2) + 16'(c) * 16'(t);
    m_cnt = m_cnt + 8'd1;
    e.a   = m_a;
    e.b   = m_b;
    e.cnt = m_cnt;
    e.lat = (sel == 2'b11) ? 4 : 2;
    sb_q.push_back(e);
  endtask

  task automatic run_req(input string name, input logic [1:0] sel,
                         input logic [7:0] x1, x2, v, t, c, input bit release_rst);
    exp_t e;
    int   n;
    int   nbusy;
    @(negedge clk);
    bus.eq_sel = sel; bus.x1 = x1; bus.x2 = x2; bus.v = v; bus.t = t; bus.c = c;
    bus.start = 1'b1;
    if (release_rst) rst_n = 1'b1;
    push_expected(sel, x1, x2, v, t, c);
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    nbusy = 0;
    while (!bus.done && n < 10) begin
      if (bus.busy) nbusy++;
      @(posedge clk); #1;
      n++;
    end
    if (bus.busy) nbusy++;
    e = sb_q.pop_front();
    n_checks++;
    if (n !== e.lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d edges required %0d", name, n, e.lat);
    end
    n_checks++;
    if (nbusy !== e.lat + 1) begin
      n_fail++;
      $display("FAIL %s busy_cycles: got %0d required %0d", name, nbusy, e.lat + 1);
    end
    n_checks++;
    if (bus.A !== e.a) begin
      n_fail++;
      $display("FAIL %s A: got %0h required %0h", name, bus.A, e.a);
    end
    n_checks++;
    if (bus.B !== e.b) begin
      n_fail++;
      $display("FAIL %s B: got %0h required %0h", name, bus.B, e.b);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_after: got done=%b busy=%b required 0 0", name, bus.done, bus.busy);
    end
    n_checks++;
    if (bus.eq_count !== e.cnt) begin
      n_fail++;
      $display("FAIL %s eq_count: got %0d required %0d", name, bus.eq_count, e.cnt);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.start = 1'b0;
    m_a = 16'h0; m_b = 16'h0; m_cnt = 8'h0;
    sb_q.delete();
    #2;
  endtask

  task automatic check_zero(input string name);
    n_checks++;
    if (bus.A !== 16'h0 || bus.B !== 16'h0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.eq_count !== 8'h0) begin
      n_fail++;
      $display("FAIL %s: got A=%0h B=%0h busy=%b done=%b cnt=%0d required all 0",
               name, bus.A, bus.B, bus.busy, bus.done, bus.eq_count);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    check_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_req("basic", 2'b11, 8'd1, 8'd3, 8'd4, 8'd2, 8'd5, 1'b0);
  endtask

  task automatic test_max();
    run_req("max", 2'b11, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0);
  endtask

  task automatic test_selective();
    run_req("preload", 2'b11, 8'd1, 8'd3, 8'd4, 8'd2, 8'd5, 1'b0);
    run_req("sel_a_only", 2'b01, 8'd0, 8'd77, 8'd10, 8'd10, 8'd9, 1'b0);
    run_req("sel_b_only", 2'b10, 8'd99, 8'd1, 8'd50, 8'd3, 8'd7, 1'b0);
  endtask

  task automatic test_sel_zero();
    int ndone;
    int nbusy;
    ndone = 0;
    nbusy = 0;
    @(negedge clk);
    bus.eq_sel = 2'b00; bus.x1 = 8'd200; bus.v = 8'd200; bus.t = 8'd200;
    bus.start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
      if (bus.busy) nbusy++;
    end
    bus.start = 1'b0;
    n_checks++;
    if (ndone !== 0 || nbusy !== 0) begin
      n_fail++;
      $display("FAIL sel_zero: got done=%0d busy=%0d cycles required 0 0", ndone, nbusy);
    end
    n_checks++;
    if (bus.A !== m_a || bus.B !== m_b || bus.eq_count !== m_cnt) begin
      n_fail++;
      $display("FAIL sel_zero_hold: got A=%0h B=%0h cnt=%0d required A=%0h B=%0h cnt=%0d",
               bus.A, bus.B, bus.eq_count, m_a, m_b, m_cnt);
    end
  endtask

  task automatic test_ignored_start();
    exp_t e;
    int   n;
    int   ndone;
    @(negedge clk);
    bus.eq_sel = 2'b11; bus.x1 = 8'd7; bus.x2 = 8'd2; bus.v = 8'd3; bus.t = 8'd5; bus.c = 8'd6;
    bus.start = 1'b1;
    push_expected(2'b11, 8'd7, 8'd2, 8'd3, 8'd5, 8'd6);
    @(posedge clk); #1;
    bus.x1 = 8'd200; bus.x2 = 8'd201; bus.v = 8'd202; bus.t = 8'd203; bus.c = 8'd204;
    n = 0;
    ndone = 0;
    while (!bus.done && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.done) ndone++;
    bus.start = 1'b0;
    e = sb_q.pop_front();
    n_checks++;
    if (n !== e.lat) begin
      n_fail++;
      $display("FAIL ignored_start latency: got %0d required %0d", n, e.lat);
    end
    n_checks++;
    if (bus.A !== e.a || bus.B !== e.b) begin
      n_fail++;
      $display("FAIL ignored_start results: got A=%0h B=%0h required A=%0h B=%0h",
               bus.A, bus.B, e.a, e.b);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    n_checks++;
    if (ndone !== 1) begin
      n_fail++;
      $display("FAIL ignored_start done_pulses: got %0d required 1", ndone);
    end
    n_checks++;
    if (bus.eq_count !== e.cnt) begin
      n_fail++;
      $display("FAIL ignored_start eq_count: got %0d required %0d", bus.eq_count, e.cnt);
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    ndone = 0;
    @(negedge clk);
    bus.eq_sel = 2'b01; bus.x1 = 8'd11; bus.v = 8'd12; bus.t = 8'd13;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid in_flight: got busy=%b done=%b required 1 0", bus.busy, bus.done);
    end
    rst_n = 1'b0;
    m_a = 16'h0; m_b = 16'h0; m_cnt = 8'h0;
    sb_q.delete();
    #1;
    check_zero("reset_mid_immediate");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    n_checks++;
    if (ndone !== 0 || bus.eq_count !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_mid no_done: got done=%0d cnt=%0d required 0 0", ndone, bus.eq_count);
    end
    run_req("after_reset", 2'b11, 8'd1, 8'd3, 8'd4, 8'd2, 8'd5, 1'b1);
  endtask

  task automatic test_back_to_back();
    test_reset();
    for (int i = 0; i < 256; i++) begin
      run_req("wrap", 2'b01, 8'(i), 8'd0, 8'd1, 8'(i), 8'd0, 1'b0);
    end
    n_checks++;
    if (bus.eq_count !== 8'h00) begin
      n_fail++;
      $display("FAIL wrap_final: got %0d required 0", bus.eq_count);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.start = 1'b0; bus.eq_sel = 2'b00;
    bus.x1 = 8'h0; bus.x2 = 8'h0; bus.v = 8'h0; bus.t = 8'h0; bus.c = 8'h0;
    m_a = 16'h0; m_b = 16'h0; m_cnt = 8'h0;
    test_reset();
    test_basic();
    test_max();
    test_selective();
    test_sel_zero();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eq_scheduler.md
EQ_SCHEDULER -- requirements
Module: eq_scheduler

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset; clears all state immediately on assertion.
REQ-004 start  input  1  request to evaluate; sampled on a rising clk edge only in IDLE.
REQ-005 eq_sel  input  2  equation select: bit0 evaluates A, bit1 evaluates B.
REQ-006 x1, x2, v, t, c  input  8 each  unsigned operands.
REQ-007 A  output  16  result A = x1 + v*t; registered.
REQ-008 B  output  16  result B = x2 + c*t; registered.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  single-cycle completion pulse; high only in DONE.
REQ-011 eq_count  output  8  count of completed requests.

Function
REQ-012 The block SHALL have one shared 8x8 unsigned multiplier with a 16-bit product register (prod) and one shared 16-bit adder; it SHALL never instantiate a second multiplier.
REQ-013 FSM states SHALL be IDLE, MUL_A, ADD_A, MUL_B, ADD_B, DONE.
REQ-014 IDLE with start=1 and eq_sel!=0 at an edge: capture x1, x2, v, t, c, eq_sel into internal registers; next state MUL_A if eq_sel[0]=1, else MUL_B.
REQ-015 IDLE with start=1 and eq_sel=0: no capture, no state change, no done, no count change.
REQ-016 MUL_A: prod <= v_cap*t_cap; next ADD_A.
REQ-017 ADD_A: A <= {8'h00,x1_cap} + prod; next MUL_B if eq_sel_cap[1]=1, else DONE.
REQ-018 MUL_B: prod <= c_cap*t_cap; next ADD_B.
REQ-019 ADD_B: B <= {8'h00,x2_cap} + prod; next DONE.
REQ-020 DONE: eq_count <= eq_count+1; next IDLE unconditionally.
REQ-021 Latency from the start-sampling edge to done high: 4 edges for eq_sel=11, 2 edges for 01 or 10; done SHALL be high for exactly one cycle.
REQ-022 Arithmetic is unsigned 16-bit. The maximum result is 255*255+255 = 0xFF00, so no overflow can occur and no saturation logic is required.
REQ-023 start asserted in any state other than IDLE (including DONE) SHALL be ignored and SHALL NOT be queued.
REQ-024 Operand changes after the capture edge SHALL NOT affect the in-flight results.
REQ-025 A result not selected by eq_sel_cap SHALL hold its previous value.
REQ-026 A and B SHALL hold their values between requests.
REQ-027 eq_count SHALL wrap from 255 to 0.

Reset
REQ-028 On rst_n=0 the block SHALL asynchronously reset to: state=IDLE, A=0, B=0, prod=0, all captured registers=0, busy=0, done=0, eq_count=0.
REQ-029 Reset asserted mid-operation SHALL abort the request with no done pulse and no count increment; the first request after release SHALL compute correctly.
REQ-030 start SHALL be honoured at the first rising edge after rst_n deasserts.

Verification
REQ-031 Basic, both equations: x1=1, x2=3, v=4, t=2, c=5, eq_sel=11, start pulse -> A=9, B=13; done high exactly 4 edges after the start edge; busy high for 5 cycles; eq_count=1.
REQ-032 Maximum operands: all operands=255, eq_sel=11 -> A=B=0xFF00.
REQ-033 Selective update: preload A=9, B=13, then v=10, t=10, x1=0, eq_sel=01 -> A=100, B stays 13, done 2 edges after start; eq_sel=00 with start -> busy stays 0, no done.
REQ-034 Ignored start and operand isolation: start re-pulsed while busy with operands changed in the cycle after capture -> results match the captured operands, exactly one done, eq_count increments by 1.
REQ-035 Reset mid-operation: assert rst_n=0 while in ADD_A -> outputs return to 0 immediately, no done; the next request with operands as in REQ-031 yields A=9, B=13.
REQ-036 Counter wrap: 256 back-to-back requests -> eq_count returns to 0.
